lab4_net_router_ctrl: RTL
=========================

# lab4_net_router_ctrl

Control unit for the three-port ring router: computes the output port for the message at the head of each input queue, arbitrates each output among competing inputs, and drives the input-queue dequeue readies, output valids and crossbar selects. It sits beside the router datapath, consuming its `inqN_val`/`inqN_dest` and producing `inqN_rdy`/`xbar_selN`. Ports 0/1/2 are west (decreasing id), terminal and east (increasing id). Messages are single-flit, so arbitration is per message.

## Interface
- `p_router_id`, 0: this router's id, 0..p_num_routers-1
- `p_num_routers`, 4: ring size; legal values 3 or 4
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high reset
- `inq0_val`/`inq1_val`/`inq2_val` in 1 each: input-queue head valid
- `inq0_rdy`/`inq1_rdy`/`inq2_rdy` out 1 each: dequeue head this cycle
- `inq0_dest`/`inq1_dest`/`inq2_dest` in 2 each: head message destination id
- `out0_val`/`out1_val`/`out2_val` out 1 each: output message valid
- `out0_rdy`/`out1_rdy`/`out2_rdy` in 1 each: downstream accepts
- `xbar_sel0`/`xbar_sel1`/`xbar_sel2` out 2 each: crossbar input index driving output N

## Operation
- Route per input: d = (dest − p_router_id) mod p_num_routers, computed in 3 bits. d==0 → port 1; 1 ≤ d ≤ floor(p_num_routers/2) → port 2; else → port 0. Tie (d==2, N=4) goes east.
- Request: input i requests output o iff `inqi_val` and route(i)==o.
- Per-output arbiter holds a 2-bit priority pointer P (values 0..2). The highest-priority input is P, then (P+1) mod 3, then (P+2) mod 3. The arbiter grants the first requester in that order.
- `outo_val` = any request to o. It depends only on request vector and P, never on `outo_rdy`, so no combinational loop is formed.
- `xbar_selo` = granted input index; 0 when no request.
- `inqi_rdy` = granted(i at route(i)) & `out_route(i)_rdy`. Each input has one route, so at most one grant per input.
- Fire on output o = `outo_val & outo_rdy`. On fire with winner w, P ← (w+1) mod 3 at the next rising edge. With no fire, P holds. This includes the case where a request is present but backpressured.
- Three outputs may fire in the same cycle; their pointers update independently.
- `inqi_dest` is ignored when `inqi_val`=0.

## Timing
- Control is combinational from inputs and P. Zero-cycle latency from `inqi_val` to `outo_val`/`inqi_rdy`.
- Only state: three 2-bit pointers, each updated on the posedge `clk` when its output fires.
- Reset: while `reset`=1, all P=0 asynchronously. All `inqi_rdy`=0, all `outo_val`=0 and all `xbar_selo`=0, regardless of inputs.
- Reset asserted mid-stream: outputs drop in the same cycle. No fire is counted, so no queue is dequeued. On deassertion, arbitration resumes with P=0.
- Pointer value 3 is unreachable. If it occurs, treat it as 0.

## Configuration
- `LAB4_NET_ROUTER_CTRL_RR_EN` defined: round-robin arbitration with pointer update as above.
- Not defined: fixed priority, input 0 > 1 > 2. Pointers are not instantiated, and P is effectively 0 forever. All other behaviour is identical.

## Test plan
- Reset: hold `reset`=1 with all `inq*_val`=1 → all `inq*_rdy`=0, `out*_val`=0, `xbar_sel*`=0. Release → first grant favors input 0.
- Routing, id=1, N=4, `inq0_val`=1: dest 1 → `out1_val`=1, sel1=0. Dest 2 → out2. Dest 3 (d=2) → out2. Dest 0 → out0, sel0=0. Each case has `inq0_rdy`=1 when the target rdy=1.
- Contention (RR_EN): all three inputs target out1 continuously with `out1_rdy`=1 → grant sequence 0,1,2,0,1,2. Without the macro → 0,0,0.
- Backpressure: inputs 1 and 2 target out0, `out0_rdy`=0 for 3 cycles → `out0_val`=1, sel0=1, `inq1_rdy`=`inq2_rdy`=0, P unchanged. Then `out0_rdy`=1 → input 1 fires, next cycle input 2 granted.
- Parallel: input 0→out2, input 1→out0, input 2→out1, all rdy=1 → all three `inq*_rdy`=1 in the same cycle. Sels are sel2=0, sel0=1, sel1=2.
- Async reset mid-stream (RR_EN): after out1 grants input 0 then 1, assert `reset` between edges → outputs drop immediately. After release, out1 grants input 0 first.

Source files
------------

// File: rtl/lab4_net_router_ctrl_if.sv
// Handshake bundle between the ring router datapath and its control unit.
// master = datapath side, slave = control unit side.
interface lab4_net_router_ctrl_if;
    logic       inq0_val;
    logic       inq1_val;
    logic       inq2_val;
    logic       inq0_rdy;
    logic       inq1_rdy;
    logic       inq2_rdy;
    logic [1:0] inq0_dest;
    logic [1:0] inq1_dest;
    logic [1:0] inq2_dest;
    logic       out0_val;
    logic       out1_val;
    logic       out2_val;
    logic       out0_rdy;
    logic       out1_rdy;
    logic       out2_rdy;
    logic [1:0] xbar_sel0;
    logic [1:0] xbar_sel1;
    logic [1:0] xbar_sel2;

    modport master (
        output inq0_val, inq1_val, inq2_val,
        output inq0_dest, inq1_dest, inq2_dest,
        output out0_rdy, out1_rdy, out2_rdy,
        input  inq0_rdy, inq1_rdy, inq2_rdy,
        input  out0_val, out1_val, out2_val,
        input  xbar_sel0, xbar_sel1, xbar_sel2
    );

    modport slave (
        input  inq0_val, inq1_val, inq2_val,
        input  inq0_dest, inq1_dest, inq2_dest,
        input  out0_rdy, out1_rdy, out2_rdy,
        output inq0_rdy, inq1_rdy, inq2_rdy,
        output out0_val, out1_val, out2_val,
        output xbar_sel0, xbar_sel1, xbar_sel2
    );
endinterface

// File: rtl/lab4_net_router_ctrl.sv
// Three-port ring router control: route, per-output arbitration, xbar selects.
// LAB4_NET_ROUTER_CTRL_RR_EN selects round-robin; otherwise fixed 0 > 1 > 2.
module lab4_net_router_ctrl #(
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 4
) (
    input logic                  clk,
    input logic                  reset,
    lab4_net_router_ctrl_if.slave rif
);

    logic [2:0]      val;
    logic [2:0]      ordy;
    logic [2:0]      irdy;
    logic [2:0]      oval;
    logic [2:0]      any;
    logic [2:0][1:0] dest;
    logic [2:0][1:0] route;
    logic [2:0][2:0] req;
    logic [2:0][1:0] sel;
    logic [2:0][1:0] xsel;
    logic [2:0][1:0] ptr;

    assign val  = {rif.inq2_val, rif.inq1_val, rif.inq0_val};
    assign ordy = {rif.out2_rdy, rif.out1_rdy, rif.out0_rdy};
    assign dest = {rif.inq2_dest, rif.inq1_dest, rif.inq0_dest};

    assign rif.inq0_rdy  = irdy[0];
    assign rif.inq1_rdy  = irdy[1];
    assign rif.inq2_rdy  = irdy[2];
    assign rif.out0_val  = oval[0];
    assign rif.out1_val  = oval[1];
    assign rif.out2_val  = oval[2];
    assign rif.xbar_sel0 = xsel[0];
    assign rif.xbar_sel1 = xsel[1];
    assign rif.xbar_sel2 = xsel[2];

    // Ring distance to the destination picks west/terminal/east; ties go east.
    function automatic logic [1:0] route_of(input logic [1:0] d);
        logic [2:0] t;
        logic [1:0] r;
        t = {1'b0, d} + 3'(p_num_routers) - 3'(p_router_id);
        if (t >= 3'(p_num_routers)) t = t - 3'(p_num_routers);
        if (t >= 3'(p_num_routers)) t = t - 3'(p_num_routers);
        if (t == 3'd0)
            r = 2'd1;
        else if (t <= 3'(p_num_routers / 2))
            r = 2'd2;
        else
            r = 2'd0;
        return r;
    endfunction

    // First requester starting at p, wrapping mod 3; pointer 3 acts as 0.
    function automatic logic [1:0] arb(input logic [2:0] rq, input logic [1:0] p);
        logic [1:0] base;
        logic [2:0] s;
        logic [1:0] idx;
        logic [1:0] g;
        logic       found;
        base  = (p == 2'd3) ? 2'd0 : p;
        g     = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s   = {1'b0, base} + 3'(k);
            idx = 2'((s >= 3'd3) ? s - 3'd3 : s);
            if (!found && rq[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        route = '0;
        req   = '0;
        sel   = '0;
        any   = '0;
        for (int i = 0; i < 3; i++)
            route[i] = route_of(dest[i]);
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++)
                req[o][i] = val[i] && (route[i] == 2'(o));
            any[o] = |req[o];
            sel[o] = arb(req[o], ptr[o]);
        end
    end

    always_comb begin
        oval = '0;
        xsel = '0;
        irdy = '0;
        if (!reset) begin
            for (int o = 0; o < 3; o++) begin
                oval[o] = any[o];
                xsel[o] = sel[o];
            end
            for (int i = 0; i < 3; i++)
                irdy[i] = val[i] && any[route[i]]
                        && (sel[route[i]] == 2'(i))
                        && ordy[route[i]];
        end
    end

`ifdef LAB4_NET_ROUTER_CTRL_RR_EN
    logic [2:0] fire;

    assign fire = oval & ordy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            for (int o = 0; o < 3; o++)
                if (fire[o])
                    ptr[o] <= (sel[o] == 2'd2) ? 2'd0 : sel[o] + 2'd1;
        end
    end
`else
    logic unused_clk;

    assign ptr        = '0;
    assign unused_clk = clk;
`endif

endmodule
